// File: rtl/cache_pkg.sv
// Shared definitions for the cache refill engine.
// Holds the refill FSM state type, the AXI4 burst/size/response encodings
// and helpers that derive index/offset widths from the line size in words.
package cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [1:0] INCR    = 2'b01;
  localparam logic [2:0] SIZE_4B = 3'b010;
  localparam logic [1:0] OKAY    = 2'b00;
  localparam logic [1:0] SLVERR  = 2'b10;

  // Bits needed to index a word within a line.
  function automatic int unsigned idx_bits(input int unsigned words);
    return $clog2(words);
  endfunction

  // Byte-offset bits of a line (word index plus 2 bits for 4-byte words).
  function automatic int unsigned off_bits(input int unsigned words);
    return $clog2(words) + 2;
  endfunction

endpackage

// File: rtl/cache_refill_engine.sv
// Cache line refill engine.
// Accepts a miss request, issues one line-aligned AXI4 INCR read burst,
// writes each returned beat into the cache data array, forwards the
// requested (critical) word to the core on the beat that carries it, and
// pulses done (with error qualifier) for one cycle when the burst ends.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready/req_addr miss request handshake and byte address
//   m_axi_ar*                   AXI4 read-address channel (master)
//   m_axi_r*                    AXI4 read-data channel (master)
//   line_wr_en/index/data       cache data-array write port
//   crit_valid/crit_data        critical-word forward to the core
//   done/error                  refill-complete pulse and error qualifier
module cache_refill_engine
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [ADDR_WIDTH-1:0]         req_addr,
  output logic [ADDR_WIDTH-1:0]         m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [DATA_WIDTH-1:0]         m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rlast,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  output logic                          line_wr_en,
  output logic [$clog2(LINE_WORDS)-1:0] line_wr_index,
  output logic [DATA_WIDTH-1:0]         line_wr_data,
  output logic                          crit_valid,
  output logic [DATA_WIDTH-1:0]         crit_data,
  output logic                          done,
  output logic                          error
);

  localparam int unsigned     IDX_W    = idx_bits(LINE_WORDS);
  localparam int unsigned     OFF_W    = off_bits(LINE_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [IDX_W-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  crit_q, crit_d;

  logic beat;
  logic crit_hit;
  logic beat_err;
  logic unused_addr_bits;

  // Byte-within-word bits of the captured address never matter.
  assign unused_addr_bits = ^addr_q[1:0];

  assign beat = (state_q == ST_DATA) && m_axi_rvalid;

  // crit_q guards against a second hit if a misbehaving slave keeps
  // sending beats after the counter has saturated at the last index.
  assign crit_hit = beat && !crit_q && (cnt_q == addr_q[OFF_W-1:2]);

  // rlast must coincide exactly with the last index; any non-OKAY response
  // also poisons the refill.
  assign beat_err = (m_axi_rresp != OKAY) ||
                    (m_axi_rlast != (cnt_q == LAST_IDX));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    crit_d  = crit_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (m_axi_arready) begin
          state_d = ST_DATA;
          cnt_d   = '0;
          err_d   = 1'b0;
          crit_d  = 1'b0;
        end
      end
      ST_DATA: begin
        if (beat) begin
          if (cnt_q != LAST_IDX) cnt_d = cnt_q + 1'b1;
          if (crit_hit)          crit_d = 1'b1;
          if (beat_err)          err_d  = 1'b1;
          if (m_axi_rlast)       state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        err_d   = 1'b0;
        cnt_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      crit_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      crit_q  <= crit_d;
    end
  end

  // Gated with rst_n so the cache controller sees no ready while held in reset.
  assign req_ready     = (state_q == ST_IDLE) && rst_n;

  assign m_axi_arvalid = (state_q == ST_ADDR);
  assign m_axi_araddr  = {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
  assign m_axi_arlen   = 8'(LINE_WORDS - 1);
  assign m_axi_arsize  = SIZE_4B;
  assign m_axi_arburst = INCR;

  assign m_axi_rready  = (state_q == ST_DATA);

  assign line_wr_en    = beat;
  assign line_wr_index = cnt_q;
  assign line_wr_data  = m_axi_rdata;

  assign crit_valid    = crit_hit;
  assign crit_data     = m_axi_rdata;

  assign done          = (state_q == ST_DONE);
  assign error         = (state_q == ST_DONE) && err_q;

endmodule

// File: tb/tb_cache_refill_engine.sv
// Scoreboard bench for cache_refill_engine: stimulus tasks push expected
// AR requests, line writes, critical words and done/error results into
// queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_cache_refill_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic        line_wr_en;
  logic [1:0]  line_wr_index;
  logic [31:0] line_wr_data;
  logic        crit_valid;
  logic [31:0] crit_data;
  logic        done, error;

  cache_refill_engine #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .LINE_WORDS(4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .m_axi_araddr  (araddr),
    .m_axi_arlen   (arlen),
    .m_axi_arsize  (arsize),
    .m_axi_arburst (arburst),
    .m_axi_arvalid (arvalid),
    .m_axi_arready (arready),
    .m_axi_rdata   (rdata),
    .m_axi_rresp   (rresp),
    .m_axi_rlast   (rlast),
    .m_axi_rvalid  (rvalid),
    .m_axi_rready  (rready),
    .line_wr_en    (line_wr_en),
    .line_wr_index (line_wr_index),
    .line_wr_data  (line_wr_data),
    .crit_valid    (crit_valid),
    .crit_data     (crit_data),
    .done          (done),
    .error         (error)
  );

  always #5 clk = ~clk;

  int unsigned tests  = 0;
  int unsigned failed = 0;

  logic [44:0] q_ar[$];    // {araddr, arlen, arsize, arburst}
  logic [33:0] q_wr[$];    // {index, data}
  logic [31:0] q_crit[$];
  logic        q_done[$];  // expected error with done

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    logic [44:0] e_ar;
    logic [33:0] e_wr;
    logic [31:0] e_crit;
    logic        e_err;
    if (rst_n) begin
      chk("error_without_done", 64'(error & ~done), 64'd0);
      if (arvalid && arready) begin
        if (q_ar.size() == 0) chk("ar_unexpected", 64'd1, 64'd0);
        else begin
          e_ar = q_ar.pop_front();
          chk("ar_request", 64'({araddr, arlen, arsize, arburst}), 64'(e_ar));
        end
      end
      if (line_wr_en) begin
        chk("wr_with_rready", 64'(rready && rvalid), 64'd1);
        if (q_wr.size() == 0) chk("wr_unexpected", 64'd1, 64'd0);
        else begin
          e_wr = q_wr.pop_front();
          chk("line_write", 64'({line_wr_index, line_wr_data}), 64'(e_wr));
        end
      end
      if (crit_valid) begin
        if (q_crit.size() == 0) chk("crit_unexpected", 64'd1, 64'd0);
        else begin
          e_crit = q_crit.pop_front();
          chk("crit_data", 64'(crit_data), 64'(e_crit));
        end
      end
      if (done) begin
        if (q_done.size() == 0) chk("done_unexpected", 64'd1, 64'd0);
        else begin
          e_err = q_done.pop_front();
          chk("done_error", 64'(error), 64'(e_err));
        end
      end
    end
  end

  task automatic push_refill(input logic [31:0] a, input logic [3:0][31:0] d,
                             input int nbeats, input logic err);
    logic [1:0] off;
    off = a[3:2];
    q_ar.push_back({a & 32'hFFFF_FFF0, 8'd3, 3'b010, 2'b01});
    for (int i = 0; i < nbeats; i++) q_wr.push_back({2'(i), d[i]});
    if (int'(off) < nbeats) q_crit.push_back(d[off]);
    q_done.push_back(err);
  endtask

  // Starts at posedge+1 with the DUT idle; returns at posedge+1 after handshake.
  task automatic send_req(input logic [31:0] a);
    int unsigned n = 0;
    req_valid = 1'b1;
    req_addr  = a;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Entered at posedge+1 in the first ADDR cycle; withholds arready 'delay' cycles.
  task automatic ar_phase(input int unsigned delay);
    logic [31:0] a0 = '0;
    logic [7:0]  l0 = '0;
    for (int unsigned i = 0; i < delay; i++) begin
      @(negedge clk);
      chk("arvalid_wait", 64'(arvalid), 64'd1);
      chk("req_ready_busy", 64'(req_ready), 64'd0);
      if (i == 0) begin
        a0 = araddr;
        l0 = arlen;
      end else begin
        chk("araddr_stable", 64'(araddr), 64'(a0));
        chk("arlen_stable", 64'(arlen), 64'(l0));
      end
      @(posedge clk); #1;
    end
    arready = 1'b1;
    @(negedge clk);
    chk("arvalid", 64'(arvalid), 64'd1);
    chk("req_ready_busy", 64'(req_ready), 64'd0);
    if (delay > 0) begin
      chk("araddr_stable", 64'(araddr), 64'(a0));
      chk("arlen_stable", 64'(arlen), 64'(l0));
    end
    @(posedge clk); #1;
    arready = 1'b0;
    chk("arvalid_drop", 64'(arvalid), 64'd0);
    chk("rready_in_data", 64'(rready), 64'd1);
  endtask

  // Drives nbeats beats (rlast on the final one), optional rvalid gap; checks done.
  task automatic r_beats(input logic [3:0][31:0] d, input logic [3:0][1:0] rs,
                         input int nbeats, input int gap_after, input int gap_len);
    for (int i = 0; i < nbeats; i++) begin
      rvalid = 1'b1;
      rdata  = d[i];
      rresp  = rs[i];
      rlast  = (i == nbeats - 1);
      @(posedge clk); #1;
      rvalid = 1'b0;
      rlast  = 1'b0;
      rresp  = 2'b00;
      if (i == gap_after) begin
        for (int g = 0; g < gap_len; g++) begin
          @(negedge clk);
          chk("gap_no_write", 64'(line_wr_en), 64'd0);
          @(posedge clk); #1;
        end
      end
    end
    @(negedge clk);
    chk("done_after_last", 64'(done), 64'd1);
    chk("req_ready_in_done", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [3:0][31:0] d;
    logic [3:0][31:0] d2;
    req_valid = 1'b0; req_addr = '0; arready = 1'b0;
    rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;

    // Reset values.
    #12;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_rready", 64'(rready), 64'd0);
    chk("rst_wr_en", 64'(line_wr_en), 64'd0);
    chk("rst_done", 64'({crit_valid, done, error}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("req_ready_after_rst", 64'(req_ready), 64'd1);
    @(posedge clk); #1;

    // Basic refill, critical word on beat 1.  d = {beat3, beat2, beat1, beat0}
    d = {32'hD, 32'hC, 32'hB, 32'hA};
    push_refill(32'h0010_0014, d, 4, 1'b0);
    send_req(32'h0010_0014);
    ar_phase(0);
    r_beats(d, '0, 4, -1, 0);

    // arready withheld 3 cycles.
    d = {32'h2004, 32'h2003, 32'h2002, 32'h2001};
    push_refill(32'h0020_0008, d, 4, 1'b0);
    send_req(32'h0020_0008);
    ar_phase(3);
    r_beats(d, '0, 4, -1, 0);

    // rvalid gap of 2 cycles between beats 1 and 2.
    d = {32'h3333_0004, 32'h3333_0003, 32'h3333_0002, 32'h3333_0001};
    push_refill(32'h0030_000C, d, 4, 1'b0);
    send_req(32'h0030_000C);
    ar_phase(0);
    r_beats(d, '0, 4, 1, 2);

    // SLVERR on beat 2 then a clean refill.
    d = {32'h4444_0004, 32'h4444_0003, 32'h4444_0002, 32'h4444_0001};
    push_refill(32'h0040_0004, d, 4, 1'b1);
    send_req(32'h0040_0004);
    ar_phase(1);
    r_beats(d, {2'b00, 2'b10, 2'b00, 2'b00}, 4, -1, 0);
    d = {32'h5555_0004, 32'h5555_0003, 32'h5555_0002, 32'h5555_0001};
    push_refill(32'h0040_0008, d, 4, 1'b0);
    send_req(32'h0040_0008);
    ar_phase(0);
    r_beats(d, '0, 4, -1, 0);

    // Early rlast on beat 2: three writes, error flagged.
    d = {32'h7777_0004, 32'h7777_0003, 32'h7777_0002, 32'h7777_0001};
    push_refill(32'h0070_0004, d, 3, 1'b1);
    send_req(32'h0070_0004);
    ar_phase(0);
    r_beats(d, '0, 3, -1, 0);

    // Reset after beat 1; only beats 0 and 1 are written.
    d = {32'h6666_0004, 32'h6666_0003, 32'h6666_0002, 32'h6666_0001};
    q_ar.push_back({32'h0060_0000, 8'd3, 3'b010, 2'b01});
    q_wr.push_back({2'd0, d[0]});
    q_wr.push_back({2'd1, d[1]});
    send_req(32'h0060_000C);
    ar_phase(0);
    for (int i = 0; i < 2; i++) begin
      rvalid = 1'b1; rdata = d[i]; rresp = 2'b00; rlast = 1'b0;
      @(posedge clk); #1;
    end
    rdata = d[2];
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs",
        64'({arvalid, rready, line_wr_en, crit_valid, done, error, req_ready}), 64'd0);
    chk("midrst_index", 64'(line_wr_index), 64'd0);
    chk("midrst_araddr", 64'(araddr), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrst_no_consume", 64'({rready, line_wr_en}), 64'd0);
    rst_n = 1'b1;
    rvalid = 1'b0;
    @(negedge clk);
    chk("req_ready_after_midrst", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    d = {32'h8888_0004, 32'h8888_0003, 32'h8888_0002, 32'h8888_0001};
    push_refill(32'h0080_0000, d, 4, 1'b0);
    send_req(32'h0080_0000);
    ar_phase(0);
    r_beats(d, '0, 4, -1, 0);

    // Back-to-back: second request held high during the first refill.
    d  = {32'h9999_0004, 32'h9999_0003, 32'h9999_0002, 32'h9999_0001};
    d2 = {32'hAAAA_0004, 32'hAAAA_0003, 32'hAAAA_0002, 32'hAAAA_0001};
    push_refill(32'h0010_0000, d, 4, 1'b0);
    send_req(32'h0010_0000);
    req_valid = 1'b1;
    req_addr  = 32'h0010_003C;
    ar_phase(0);
    r_beats(d, '0, 4, -1, 0);
    push_refill(32'h0010_003C, d2, 4, 1'b0);
    @(negedge clk);
    chk("req_ready_after_done", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    ar_phase(0);
    r_beats(d2, '0, 4, -1, 0);

    repeat (5) @(posedge clk);
    #1;
    chk("q_ar_empty", 64'(q_ar.size()), 64'd0);
    chk("q_wr_empty", 64'(q_wr.size()), 64'd0);
    chk("q_crit_empty", 64'(q_crit.size()), 64'd0);
    chk("q_done_empty", 64'(q_done.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
